// File: rtl/fc_in_buffer.sv
// Serial-to-parallel activation buffer feeding a fully-connected layer: collects IN
// beats into x[0:IN-1] and holds them until x_ready. Define FC_IN_PINGPONG_EN for two banks.

module fc_in_lane #(
  parameter int WIDTH = 8,
  parameter int NBANK = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NBANK-1:0]            we,
  input  logic [WIDTH-1:0]            d,
  output logic [NBANK-1:0][WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      for (int b = 0; b < NBANK; b++) begin
        if (we[b]) q[b] <= d;
      end
    end
  end

endmodule

module fc_in_buffer #(
  parameter int WIDTH = 8,
  parameter int IN    = 84
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] x [0:IN-1],
  output logic             x_valid,
  input  logic             x_ready,
  output logic             err
);

`ifdef FC_IN_PINGPONG_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif
  localparam int IW = (IN > 1) ? $clog2(IN) : 1;

  logic [IW-1:0]                wr_idx;
  logic                         accept;
  logic                         last_slot;
  logic                         done;
  logic [NBANK-1:0]             bank_we;
  logic [NBANK-1:0][WIDTH-1:0]  lane_q [IN];

  assign accept    = in_valid && in_ready;
  assign last_slot = (wr_idx == IW'(IN - 1));
  assign done      = accept && last_slot;

  // Any in_last/slot disagreement is a length error; a short frame also restarts at slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx <= '0;
      err    <= 1'b0;
    end else if (accept) begin
      wr_idx <= (last_slot || in_last) ? '0 : wr_idx + 1'b1;
      if (in_last != last_slot) err <= 1'b1;
    end
  end

`ifdef FC_IN_PINGPONG_EN
  logic [1:0] full, full_nx;
  logic       wr_bank, rd_bank, wr_nx, rd_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      full    <= full_nx;
      wr_bank <= wr_nx;
      rd_bank <= rd_nx;
    end
  end

  // Release and completion may land together; they always touch different banks.
  always_comb begin
    full_nx = full;
    wr_nx   = wr_bank;
    rd_nx   = rd_bank;
    if (x_valid && x_ready) begin
      full_nx[rd_bank] = 1'b0;
      rd_nx            = ~rd_bank;
    end
    if (done) begin
      full_nx[wr_bank] = 1'b1;
      wr_nx            = ~wr_bank;
    end
  end

  assign in_ready = ~&full;
  assign x_valid  = full[rd_bank];
  assign bank_we  = {accept & wr_bank, accept & ~wr_bank};
`else
  typedef enum logic {FILL, FULL} state_t;
  state_t state, state_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FILL:    if (done)    state_nx = FULL;
      FULL:    if (x_ready) state_nx = FILL;
      default:              state_nx = FILL;
    endcase
  end

  assign in_ready = (state == FILL);
  assign x_valid  = (state == FULL);
  assign bank_we  = accept;
`endif

  for (genvar k = 0; k < IN; k++) begin : g_lane
    fc_in_lane #(.WIDTH(WIDTH), .NBANK(NBANK)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (bank_we & {NBANK{wr_idx == IW'(k)}}),
      .d     (in_data),
      .q     (lane_q[k])
    );
`ifdef FC_IN_PINGPONG_EN
    assign x[k] = lane_q[k][rd_bank];
`else
    assign x[k] = lane_q[k][0];
`endif
  end

endmodule

// File: tb/tb_fc_in_buffer.sv
// Randomised bench for fc_in_buffer: a queue model of complete/partial frames is
// compared against the DUT every cycle, plus literal checks from hand-worked scenarios.

module tb_fc_in_buffer;
  localparam int W  = 8;
  localparam int IN = 84;
`ifdef FC_IN_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_valid, in_last, in_ready;
  logic [W-1:0] x [0:IN-1];
  logic         x_valid, x_ready, err;

  fc_in_buffer #(.WIDTH(W), .IN(IN)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .x(x), .x_valid(x_valid),
    .x_ready(x_ready), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit en     = 1'b0;
  bit rnd_xr = 1'b0;
  int hs_n   = 0;
  int hs_cyc[$];

  // Model: m_q holds beats of complete frames awaiting consumption, m_cur the partial frame.
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_cur[$];
  bit           m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst_n) begin
    bit acc, rel;
    if (!rst_n) begin
      m_q.delete();
      m_cur.delete();
      m_err = 1'b0;
    end else begin
      acc = in_valid && ((m_q.size() / IN) < NB);
      rel = (m_q.size() > 0) && x_ready;
      if (rel) repeat (IN) void'(m_q.pop_front());
      if (acc) begin
        m_cur.push_back(in_data);
        if (m_cur.size() == IN) begin
          foreach (m_cur[i]) m_q.push_back(m_cur[i]);
          if (!in_last) m_err = 1'b1;
          m_cur.delete();
        end else if (in_last) begin
          m_err = 1'b1;
          m_cur.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("in_ready", in_ready, ((m_q.size() / IN) < NB));
      chk("x_valid", x_valid, (m_q.size() > 0));
      chk("err", err, m_err);
      if (m_q.size() > 0) begin
        int bad = 0;
        for (int k = 0; k < IN; k++) begin
          if (x[k] !== m_q[k]) begin bad = k; break; end
        end
        chk("x_elem", x[bad], m_q[bad]);
      end
    end
    if (rst_n && x_valid && x_ready) begin
      hs_n++;
      hs_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_xr) x_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic beat(input logic [W-1:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && n < 600) begin
      tick();
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL beat_timeout actual=0 required=1 t=%0t", $time);
    end
    tick();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_x_valid", x_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_err", err, 0);
    chk("rst_x0", x[0], 0);
    chk("rst_xlast", x[IN-1], 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [W-1:0] snap [IN];
    int same, base;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; x_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    en = 1'b1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_x_valid", x_valid, 0);
    chk("reset_err", err, 0);
    chk("reset_x0", x[0], 0);
    rst_n = 1'b1;
    tick();

    // One frame 1..84 held with x_ready low.
    for (int k = 0; k < IN; k++) beat(W'(k + 1), k == IN - 1);
    in_valid = 1'b0; in_last = 1'b0;
    chk("t1_x_valid", x_valid, 1);
    chk("t1_x0", x[0], 1);
    chk("t1_x83", x[IN-1], 84);
    chk("t1_in_ready", in_ready, (NB == 2));
    foreach (snap[k]) snap[k] = x[k];
    idle(20);
    same = 1;
    foreach (snap[k]) if (x[k] !== snap[k]) same = 0;
    chk("t1_hold20", same, 1);
    chk("t1_hold_valid", x_valid, 1);
    x_ready = 1'b1;
    idle(2);

    // Three back-to-back frames with x_ready high.
    hs_cyc.delete();
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < IN; k++) beat(W'($urandom), k == IN - 1);
    idle(4);
    chk("t2_pulses", hs_cyc.size(), 3);
    if (hs_cyc.size() == 3) begin
      chk("t2_gap01", hs_cyc[1] - hs_cyc[0], IN + (NB == 1));
      chk("t2_gap12", hs_cyc[2] - hs_cyc[1], IN + (NB == 1));
    end

    // Short frame followed by a good frame.
    x_ready = 1'b0;
    chk("t3_err_before", err, 0);
    for (int k = 0; k < 10; k++) beat(W'(k + 50), k == 9);
    in_valid = 1'b0; in_last = 1'b0;
    chk("t3_err_short", err, 1);
    chk("t3_no_valid", x_valid, 0);
    for (int k = 0; k < IN; k++) beat(W'(k + 100), k == IN - 1);
    in_valid = 1'b0; in_last = 1'b0;
    chk("t3_x_valid", x_valid, 1);
    chk("t3_x0", x[0], 100);
    chk("t3_err_sticky", err, 1);
    x_ready = 1'b1;
    idle(2);
    x_ready = 1'b0;

    // Missing in_last: frame still delivered, err raised.
    do_reset();
    for (int k = 0; k < IN; k++) beat(W'(k * 2 + 1), 1'b0);
    in_valid = 1'b0;
    chk("t4_x_valid", x_valid, 1);
    chk("t4_x83", x[IN-1], 167);
    chk("t4_err", err, 1);

    // Reset withdraws the presented frame; reset mid-frame drops partial data.
    do_reset();
    for (int k = 0; k < 40; k++) beat(W'(k + 180), 1'b0);
    do_reset();
    for (int k = 0; k < IN; k++) beat(W'((k + 7) * 3), k == IN - 1);
    in_valid = 1'b0; in_last = 1'b0;
    chk("t5_x_valid", x_valid, 1);
    chk("t5_x0", x[0], 21);
    chk("t5_err", err, 0);
    x_ready = 1'b1;
    idle(2);

    // Random throttling on both sides, 50 frames.
    base   = hs_n;
    rnd_xr = 1'b1;
    for (int f = 0; f < 50; f++) begin
      for (int k = 0; k < IN; k++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        beat(W'($urandom), k == IN - 1);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    for (int n = 0; n < 2000 && (hs_n - base) < 50; n++) tick();
    rnd_xr  = 1'b0;
    x_ready = 1'b1;
    idle(3);
    chk("t6_frames", hs_n - base, 50);
    chk("t6_err", err, 0);

    en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
